// File: rtl/adc_sample_averager_if.sv
// ADC request/complete handshake between the sample averager (master) and the SPI ADC front end (slave).
interface adc_sample_averager_if;
  logic        adc_read;
  logic        adc_read_done;
  logic [11:0] adc_value;

  modport master (output adc_read, input adc_read_done, input adc_value);
  modport slave  (input adc_read, output adc_read_done, output adc_value);
endinterface

// File: rtl/adc_sample_averager.sv
// Periodically requests ADC conversions, captures each sample and emits a block
// average of 2^LOG2_AVG samples with a threshold flag and a sticky conversion timeout.
module adc_sample_averager #(
  parameter int unsigned SAMPLE_PERIOD = 48000,
  parameter int unsigned LOG2_AVG      = 4,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [11:0]                  threshold,
  adc_sample_averager_if.master        adc,
  output logic [11:0]                  sample,
  output logic                         sample_valid,
  output logic [11:0]                  avg_value,
  output logic                         avg_valid,
  output logic                         over_threshold,
  output logic                         timeout_err
);

  localparam int unsigned ACC_W = 12 + LOG2_AVG;
  localparam int unsigned CNT_W = LOG2_AVG + 1;
  localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQUEST, RELEASE} state_t;

  state_t             state, state_next;
  logic               sync1, done_s, done_s_d, done_rise;
  logic [PER_W-1:0]   period_cnt;
  logic               tick;
  logic [TO_W-1:0]    to_cnt;
  logic               to_hit;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic [CNT_W-1:0]   n_cnt;
  logic               block_done;
  logic [11:0]        avg_next;
  logic               read_req, capture, abort;

  assign done_rise  = done_s & ~done_s_d;
  assign tick       = (period_cnt == PER_W'(SAMPLE_PERIOD - 1));
  assign to_hit     = (to_cnt == TO_W'(TIMEOUT - 1));
  assign acc_sum    = acc + ACC_W'(adc.adc_value);
  assign avg_next   = 12'(acc_sum >> LOG2_AVG);
  assign block_done = (n_cnt == CNT_W'((1 << LOG2_AVG) - 1));
  assign adc.adc_read = read_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sync1    <= 1'b0;
      done_s   <= 1'b0;
      done_s_d <= 1'b0;
    end else begin
      state    <= state_next;
      sync1    <= adc.adc_read_done;
      done_s   <= sync1;
      done_s_d <= done_s;
    end
  end

  // A completion wins over a timeout landing in the same cycle.
  always_comb begin
    state_next = state;
    read_req   = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick && enable) state_next = REQUEST;
      end
      REQUEST: begin
        read_req = 1'b1;
        if (done_rise) begin
          capture    = 1'b1;
          state_next = RELEASE;
        end else if (to_hit) begin
          abort      = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!done_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      if (!enable || tick) period_cnt <= '0;
      else                 period_cnt <= period_cnt + PER_W'(1);
      if (state == IDLE)         to_cnt <= '0;
      else if (state == REQUEST) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc            <= '0;
      n_cnt          <= '0;
      sample         <= '0;
      sample_valid   <= 1'b0;
      avg_value      <= '0;
      avg_valid      <= 1'b0;
      over_threshold <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      avg_valid    <= 1'b0;
      if (capture) begin
        sample       <= adc.adc_value;
        sample_valid <= 1'b1;
        if (block_done) begin
          acc            <= '0;
          n_cnt          <= '0;
          avg_value      <= avg_next;
          avg_valid      <= 1'b1;
          over_threshold <= (avg_next >= threshold);
        end else begin
          acc   <= acc_sum;
          n_cnt <= n_cnt + CNT_W'(1);
        end
      end
      if (abort) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench: an asynchronous ADC model feeds a block-average reference model;
// a negedge monitor pops expected samples/averages whenever the averager presents them.
module tb_adc_sample_averager;
  localparam int unsigned SP   = 100;
  localparam int unsigned L2   = 2;
  localparam int unsigned TO   = 16;
  localparam int unsigned NAVG = 1 << L2;

  typedef enum {M_NORMAL, M_SILENT, M_LONG, M_HOLD} mode_t;
  typedef struct { mode_t mode; logic [11:0] value; } entry_t;
  typedef struct { logic [11:0] avg; bit over; } avg_exp_t;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [11:0] threshold;
  logic [11:0] sample, avg_value;
  logic        sample_valid, avg_valid, over_threshold, timeout_err;

  adc_sample_averager_if ifc();

  adc_sample_averager #(.SAMPLE_PERIOD(SP), .LOG2_AVG(L2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .threshold(threshold), .adc(ifc),
    .sample(sample), .sample_valid(sample_valid), .avg_value(avg_value),
    .avg_valid(avg_valid), .over_threshold(over_threshold), .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  int          checks = 0, errors = 0;
  entry_t      script[$];
  logic [11:0] exp_samples[$];
  avg_exp_t    exp_avgs[$];
  int          block[$];
  int          served = 0;
  bit          model_busy = 1'b0;
  bit          last_over = 1'b0;
  bit          prev_read = 1'b0;
  longint      cyc = 0, last_rise = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: every delivered conversion is a sample; every NAVG samples form a truncated mean.
  task automatic model_sample(input logic [11:0] v);
    int sum;
    exp_samples.push_back(v);
    block.push_back(int'(v));
    if (block.size() == NAVG) begin
      sum = 0;
      foreach (block[i]) sum += block[i];
      exp_avgs.push_back('{avg: 12'(sum / NAVG), over: ((sum / NAVG) >= int'(threshold))});
      block.delete();
    end
  endtask

  task automatic push(input mode_t m, input logic [11:0] v);
    script.push_back('{m, v});
  endtask

  // Wait until the script is consumed and the handshake is quiet, then stop sampling.
  task automatic wait_drain(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (script.size() == 0 && !model_busy && !ifc.adc_read && !ifc.adc_read_done) break;
    end
    enable = 1'b0;
    check({name, "_drained"}, longint'(k < budget), 1);
    repeat (6) @(negedge clk);
  endtask

  // ADC model: asynchronous response to each request level.
  initial begin : adc_model
    entry_t e;
    int     n, d, stray;
    ifc.adc_read_done = 1'b0;
    ifc.adc_value     = '0;
    forever begin
      @(posedge ifc.adc_read);
      model_busy = 1'b1;
      if (script.size() > 0) e = script.pop_front();
      else                   e = '{M_NORMAL, 12'($urandom)};
      served++;
      if (e.mode == M_NORMAL || e.mode == M_LONG) begin
        d = 10 * $urandom_range(1, 7) + 3;
        #(d);
        ifc.adc_value = e.value;
        #2;
        ifc.adc_read_done = 1'b1;
        model_sample(e.value);
        n = 0;
        for (int k = 0; k < 50 && ifc.adc_read; k++) begin
          @(negedge clk);
          if (ifc.adc_read) n++;
        end
        check("read_release_latency", longint'(n >= 2 && n <= 3), 1);
        if (e.mode == M_LONG) begin
          stray = 0;
          for (int k = 0; k < 3 * SP; k++) begin
            @(negedge clk);
            if (ifc.adc_read) stray++;
          end
          check("overrun_read_while_done", stray, 0);
        end else begin
          #($urandom_range(10, 200));
        end
        ifc.adc_read_done = 1'b0;
        #3;
        ifc.adc_value = 12'($urandom);
      end else if (e.mode == M_SILENT) begin
        n = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (!ifc.adc_read) break;
          n++;
        end
        check("timeout_read_len", n, TO);
      end else begin
        for (int k = 0; k < 200 && ifc.adc_read; k++) @(negedge clk);
      end
      model_busy = 1'b0;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    avg_exp_t ea;
    if (!reset) begin
      if (sample_valid) begin
        check("sample_expected", longint'(exp_samples.size() > 0), 1);
        if (exp_samples.size() > 0) check("sample_value", sample, exp_samples.pop_front());
        if (!avg_valid) check("over_hold", over_threshold, last_over);
      end
      if (avg_valid) begin
        check("avg_with_sample", sample_valid, 1);
        check("avg_expected", longint'(exp_avgs.size() > 0), 1);
        if (exp_avgs.size() > 0) begin
          ea = exp_avgs.pop_front();
          check("avg_value", avg_value, ea.avg);
          check("over_threshold", over_threshold, ea.over);
          last_over = ea.over;
        end
      end
      if (!enable) last_rise = -1;
      if (ifc.adc_read && !prev_read) begin
        if (last_rise >= 0) check("request_period", (cyc - last_rise) % SP, 0);
        last_rise = cyc;
      end
    end
    prev_read = ifc.adc_read;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog act=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k, base, n0;
    reset = 1'b1; enable = 1'b0; threshold = '0;
    repeat (3) @(negedge clk);
    check("rst_adc_read", ifc.adc_read, 0);
    check("rst_sample", sample, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_avg_value", avg_value, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_over", over_threshold, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;

    // Basic average with threshold at the boundary, then one above it.
    for (int t = 0; t < 3; t++) begin
      threshold = (t == 2) ? 12'd251 : 12'd250;
      push(M_NORMAL, 12'd100); push(M_NORMAL, 12'd200);
      push(M_NORMAL, 12'd300); push(M_NORMAL, 12'd400);
      enable = 1'b1;
      wait_drain("basic", 8 * SP);
    end

    // Truncation at full scale.
    threshold = 12'd4095;
    push(M_NORMAL, 12'd4095); push(M_NORMAL, 12'd4095);
    push(M_NORMAL, 12'd4095); push(M_NORMAL, 12'd4094);
    enable = 1'b1;
    wait_drain("trunc", 8 * SP);

    // Random blocks with a random threshold each.
    for (int b = 0; b < 3; b++) begin
      threshold = 12'($urandom);
      for (int i = 0; i < NAVG; i++) push(M_NORMAL, 12'($urandom));
      enable = 1'b1;
      wait_drain("random", 8 * SP);
    end

    // Enable dropped mid-request: request completes, partial block resumes later.
    threshold = 12'($urandom);
    for (int i = 0; i < NAVG; i++) push(M_NORMAL, 12'($urandom));
    enable = 1'b1;
    for (k = 0; k < 3 * SP && !ifc.adc_read; k++) @(negedge clk);
    check("en_request_seen", ifc.adc_read, 1);
    enable = 1'b0;
    for (k = 0; k < 200 && (model_busy || ifc.adc_read || ifc.adc_read_done); k++) @(negedge clk);
    n0 = served;
    repeat (3 * SP) @(negedge clk);
    check("en_off_no_request", served - n0, 0);
    enable = 1'b1;
    wait_drain("enable", 8 * SP);

    // Timeout: silent conversion, then normal requests resume.
    base = served;
    push(M_SILENT, '0);
    for (int i = 0; i < NAVG; i++) push(M_NORMAL, 12'($urandom));
    enable = 1'b1;
    wait_drain("timeout", 10 * SP);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_fresh_requests", served - base, NAVG + 1);

    // Overrun: done held through several ticks.
    base = served;
    push(M_LONG, 12'($urandom)); push(M_LONG, 12'($urandom));
    push(M_NORMAL, 12'($urandom)); push(M_NORMAL, 12'($urandom));
    enable = 1'b1;
    wait_drain("overrun", 20 * SP);
    check("overrun_one_per_pulse", served - base, NAVG);
    check("timeout_err_sticky", timeout_err, 1);

    // Reset while a request is outstanding after 2 of 4 samples.
    base = served;
    push(M_NORMAL, 12'($urandom)); push(M_NORMAL, 12'($urandom)); push(M_HOLD, '0);
    enable = 1'b1;
    for (k = 0; k < 6 * SP && !(served == base + 3 && ifc.adc_read); k++) @(negedge clk);
    check("reset_request_seen", longint'(served == base + 3 && ifc.adc_read), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    block.delete();
    last_over = 1'b0;
    last_rise = -1;
    @(posedge clk);
    #1;
    check("mrst_adc_read", ifc.adc_read, 0);
    check("mrst_sample", sample, 0);
    check("mrst_avg_value", avg_value, 0);
    check("mrst_over", over_threshold, 0);
    check("mrst_timeout_err", timeout_err, 0);
    @(negedge clk);
    reset = 1'b0;
    threshold = 12'($urandom);
    for (int i = 0; i < NAVG; i++) push(M_NORMAL, 12'($urandom));
    wait_drain("post_reset", 8 * SP);

    check("left_samples", exp_samples.size(), 0);
    check("left_avgs", exp_avgs.size(), 0);
    check("left_block", block.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Sits directly downstream of the SPI ADC front end, in the 48 MHz system clock domain.
- Issues periodic `read` requests to the ADC and completes the handshake on `read_done`.
- Captures each 12-bit sample and accumulates 2^LOG2_AVG samples into a block average for the control logic.
- Flags averages at or above a programmable threshold, and flags ADC conversions that never complete.

Parameters:
- SAMPLE_PERIOD, 48000: system clocks between request starts (1 kHz at 48 MHz); must be > TIMEOUT + 8.
- LOG2_AVG, 4: log2 of samples per average (16); legal range 0..8.
- TIMEOUT, 1024: system clocks to wait for read_done before aborting a request.

Ports:
- clk  in  1  system clock, 48 MHz.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = sampling runs; 0 = no new requests (a request in flight completes).
- threshold  in  12  over-threshold compare level, unsigned.
- adc_read  out  1  request to ADC, level.
- adc_read_done  in  1  ADC completion flag, asynchronous to clk (slow ADC clock domain).
- adc_value  in  12  ADC sample; stable while adc_read_done is high.
- sample  out  12  last raw captured sample.
- sample_valid  out  1  one-clk pulse when `sample` updates.
- avg_value  out  12  block average.
- avg_valid  out  1  one-clk pulse when `avg_value` updates.
- over_threshold  out  1  1 when the last avg_value >= threshold.
- timeout_err  out  1  sticky; set on request timeout, cleared only by reset.

Behaviour:
- Reset values: all outputs 0, accumulator 0, sample count 0, period counter 0, synchroniser flops 0, state IDLE.
- Synchronisation:
  - adc_read_done passes through a 2-flop synchroniser giving done_s; done_rise = done_s & ~done_s_d.
  - adc_value is captured only on done_rise; no separate synchroniser, since it is stable while done is high.
- Period counter:
  - Free-runs 0..SAMPLE_PERIOD-1 while enable=1, wrapping to 0.
  - Held at 0 while enable=0.
  - tick = (count == SAMPLE_PERIOD-1).
- FSM states:
  - IDLE: adc_read=0. On tick with enable=1 -> REQUEST; clear the timeout counter.
  - REQUEST: adc_read=1; the timeout counter increments each clk.
    - On done_rise: sample <= adc_value; sample_valid pulse next cycle; accumulate; go to RELEASE.
    - If the timeout counter reaches TIMEOUT-1 without done_rise: timeout_err <= 1; no accumulate; go to RELEASE.
  - RELEASE: adc_read=0. Wait until done_s == 0, then -> IDLE.
    - Prevents a stale level from being taken as a new completion.
    - No timeout in this state.
- Tick handling outside IDLE: a tick while in REQUEST or RELEASE is dropped (overrun). No queueing.
- Accumulator:
  - Width 12+LOG2_AVG; adds the zero-extended sample, so it cannot overflow.
  - On the 2^LOG2_AVG-th sample: avg_value <= (acc + sample) >> LOG2_AVG (truncating); avg_valid pulses; over_threshold <= (avg >= threshold); accumulator and count reset to 0 in the same cycle.
  - LOG2_AVG=0: every sample is also an average.
- avg_valid and sample_valid assert in the same cycle for the completing sample.
- enable falling mid-REQUEST: the request completes normally. The partial accumulation is kept and resumes when enable returns.
- threshold is sampled only at average update; over_threshold holds between updates.
- Reset mid-operation: adc_read drops the next clk; the partial average is discarded.

Test Plan:
- Basic average: SAMPLE_PERIOD=100, LOG2_AVG=2; ADC model returns 100, 200, 300, 400 -> four sample_valid pulses, one avg_valid with avg_value=250, adc_read high only between tick and done.
- Threshold: threshold=250 with the same data -> over_threshold=1; threshold=251 -> over_threshold=0; the flag holds until the next avg_valid.
- Truncation and max: LOG2_AVG=2, samples 4095, 4095, 4095, 4094 -> avg_value=4094; no overflow.
- Timeout: ADC model never raises done, TIMEOUT=16 -> adc_read high exactly 16 clks, timeout_err=1 (sticky), no sample_valid; the next tick issues a fresh request.
- Slow release/overrun: done held high for longer than SAMPLE_PERIOD -> block stays in RELEASE, ticks are dropped, and exactly one sample is taken per done pulse.
- Reset mid-request: assert reset while adc_read=1 after 2 of 4 samples -> all outputs 0 next clk; after release, the first average uses only 4 new samples.
